// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W = 5;

    typedef enum logic {
        M_IDLE = 1'b0,
        M_WAIT = 1'b1
    } mem_state_e;

    localparam logic [1:0]       FWD_RF  = 2'b00;
    localparam logic [1:0]       FWD_WB  = 2'b01;
    localparam logic [1:0]       FWD_MEM = 2'b10;
    localparam logic [REG_W-1:0] REG_X0  = '0;

endpackage

// File: rtl/fwd_unit.sv
// Per-operand EX bypass select: EX/MEM ALU result beats MEM/WB, x0 never bypassed.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_reg_write,
    input  logic             mem_read,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_reg_write,
    output logic [1:0]       fwd_sel_c
);

    // A load in EX/MEM has no data yet, so only ALU results bypass from there.
    always_comb begin
        fwd_sel_c = FWD_RF;
        if (mem_reg_write && !mem_read && (mem_rd != REG_X0) && (mem_rd == ex_rs)) begin
            fwd_sel_c = FWD_MEM;
        end else if (wb_reg_write && (wb_rd != REG_X0) && (wb_rd == ex_rs)) begin
            fwd_sel_c = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register sequencing for the 5-stage core: stalls, flushes, bypass
// selects, data-memory handshake with timeout, and a saturating stall counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TO_W        = 5,
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic                   id_use_rs1,
    input  logic                   id_use_rs2,
    input  logic [4:0]             ex_rs1,
    input  logic [4:0]             ex_rs2,
    input  logic [4:0]             ex_rd,
    input  logic                   ex_reg_write,
    input  logic                   ex_mem_read,
    input  logic                   ex_branch_taken,
    input  logic [4:0]             mem_rd,
    input  logic                   mem_reg_write,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [4:0]             wb_rd,
    input  logic                   wb_reg_write,
    input  logic                   dmem_ack,
    output logic                   pc_en,
    output logic                   if_id_en,
    output logic                   id_ex_en,
    output logic                   ex_mem_en,
    output logic                   mem_wb_en,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic [1:0]             fwd_a_sel,
    output logic [1:0]             fwd_b_sel,
    output logic                   dmem_req,
    output logic                   mem_err,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    mem_state_e             state_q, state_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic                   mem_err_q, mem_err_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic       mem_op, timeout, mem_done, mem_stall, load_use;
    logic [1:0] fwd_a_c, fwd_b_c;

    assign mem_op    = mem_read | mem_write;
    assign timeout   = (state_q == M_WAIT) && (to_cnt_q == TO_W'(MEM_TIMEOUT - 1));
    assign mem_done  = (state_q == M_WAIT) && (dmem_ack || timeout);
    assign mem_stall = mem_op && !mem_done;
    assign load_use  = ex_mem_read && ex_reg_write && (ex_rd != REG_X0) &&
                       ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    fwd_unit u_fwd_a (
        .ex_rs         (ex_rs1),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_read      (mem_read),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .fwd_sel_c     (fwd_a_c)
    );

    fwd_unit u_fwd_b (
        .ex_rs         (ex_rs2),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_read      (mem_read),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .fwd_sel_c     (fwd_b_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= M_IDLE;
            to_cnt_q    <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Memory handshake: an access always spends at least one cycle in M_WAIT.
    always_comb begin
        state_d   = state_q;
        to_cnt_d  = '0;
        mem_err_d = timeout && !dmem_ack;
        if (state_q == M_IDLE) begin
            if (mem_op) begin
                state_d = M_WAIT;
            end
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
            if (mem_done) begin
                state_d = M_IDLE;
            end
        end
    end

    // Hazard priority: memory stall, then taken branch, then load-use bubble.
    always_comb begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_en    = 1'b0;
        ex_mem_en   = 1'b0;
        mem_wb_en   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        fwd_a_sel   = FWD_RF;
        fwd_b_sel   = FWD_RF;
        if (!rst) begin
            fwd_a_sel = fwd_a_c;
            fwd_b_sel = fwd_b_c;
            if (!mem_stall) begin
                id_ex_en  = 1'b1;
                ex_mem_en = 1'b1;
                mem_wb_en = 1'b1;
                if (ex_branch_taken) begin
                    pc_en       = 1'b1;
                    if_id_en    = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    id_ex_flush = 1'b1;
                end else begin
                    pc_en    = 1'b1;
                    if_id_en = 1'b1;
                end
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    assign dmem_req  = (state_q == M_WAIT);
    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule
